// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Used by fetch_unit and its instruction buffer, fetch_fifo.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // Encodes addi x0,x0,0; shown to decode whenever no instruction is valid.
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: pointer-based FIFO of fetch entries, head read straight from storage.
// Push and pop may share a cycle even when full; flush clears it in one cycle and wins over both.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch: credit-limited sequential requests, in-order responses buffered toward decode; redirects flush.
// Optional FETCH_BYPASS_EN forwards a live response straight to decode when the buffer is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  fetch_entry_t  head_dat, push_dat;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic          req_fire, resp_live, bypass_vld, bypass_take;
  logic [31:0]   redirect_pc_al;
  logic [CW:0]   credit_used;

  assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;

  // Buffered plus in-flight never exceeds the buffer depth, so every response has a slot.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_live = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_vld = fifo_empty && resp_live;
`else
  assign bypass_vld = 1'b0;
`endif
  assign bypass_take = bypass_vld && instr_ready;

  assign instr_valid = !fifo_empty || bypass_vld;
  assign instr       = !fifo_empty ? head_dat.instr : (bypass_vld ? imem_resp_data : INSTR_NOP);
  assign instr_pc    = fifo_empty  ? resp_pc_q : head_dat.pc;

  assign fifo_pop  = !fifo_empty && instr_ready && !redirect_valid;
  assign fifo_push = resp_live && !bypass_take;
  assign push_dat  = '{instr: imem_resp_data, pc: resp_pc_q};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path; a response landing now is one of them.
      fetch_pc_d = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
      drop_cnt_d = outstanding_q - CW'(imem_resp_valid);
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_live) resp_pc_d  = resp_pc_q + 32'd4;
      if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .flush    (redirect_valid),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  resp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (outstanding_q != '0));
  push_into_full: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_push && !fifo_pop && !redirect_valid) |-> !fifo_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based model of memory, buffer and redirect epochs.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        memq[$];
  req_t        cur;
  logic [31:0] bq_i[$], bq_pc[$];
  logic [31:0] dq[$], fq[$];
  logic [31:0] m_fetch_pc;
  int          m_epoch, cyc, last_due, lat_min, lat_max;
  int          n_chk, n_fail, n_dut_fire;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    memq.delete(); bq_i.delete(); bq_pc.delete(); dq.delete(); fq.delete();
    m_fetch_pc = 32'h0; m_epoch = 0; last_due = cyc; n_dut_fire = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_vld", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_instr_vld", instr_valid, 0);
    check("rst_instr", instr, INSTR_NOP);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_req_vld", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, 32'h0);
  endtask

  task automatic step(input logic rdy, input logic irdy, input logic redir, input logic [31:0] rpc);
    int          out_n, due;
    logic        exp_req, live, byp, ev, took_byp;
    logic [31:0] ei, ep;
    @(posedge clk); #1;
    imem_req_ready = rdy; instr_ready = irdy;
    redirect_valid = redir; redirect_pc = rpc;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      cur = memq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(cur.addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom();
    end
    @(negedge clk);
    out_n   = memq.size() + (imem_resp_valid ? 1 : 0);
    exp_req = (bq_i.size() + out_n < 4) && !redir;
    check("req_vld", imem_req_valid, exp_req);
    check("req_addr", imem_req_addr, m_fetch_pc);
    live = imem_resp_valid && (cur.epoch == m_epoch) && !redir;
    byp  = 1'b0;
    if (bq_i.size() > 0) begin
      ev = 1'b1; ei = bq_i[0]; ep = bq_pc[0];
    end else begin
      ev = 1'b0; ei = INSTR_NOP; ep = '0;
`ifdef FETCH_BYPASS_EN
      if (live) begin ev = 1'b1; ei = mem_word(cur.addr); ep = cur.addr; byp = 1'b1; end
`endif
    end
    check("instr_vld", instr_valid, ev);
    check("instr", instr, ei);
    if (ev) check("instr_pc", instr_pc, ep);
    if (imem_req_valid && imem_req_ready) begin n_dut_fire++; fq.push_back(imem_req_addr); end
    if (instr_valid && instr_ready && !redir) dq.push_back(instr_pc);
    if (redir) begin
      bq_i.delete(); bq_pc.delete();
      m_epoch++;
      m_fetch_pc = rpc & ~32'h3;
    end else begin
      took_byp = 1'b0;
      if (ev && irdy) begin
        if (byp) took_byp = 1'b1;
        else begin void'(bq_i.pop_front()); void'(bq_pc.pop_front()); end
      end
      if (live && !took_byp) begin bq_i.push_back(mem_word(cur.addr)); bq_pc.push_back(cur.addr); end
      if (exp_req && rdy) begin
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        memq.push_back('{addr: m_fetch_pc, due: due, epoch: m_epoch});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    logic saw_wrap;
    n_chk = 0; n_fail = 0; cyc = 0;

    // Steady stream, 1-cycle memory latency.
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (24) step(1'b1, 1'b1, 1'b0, '0);
`ifdef FETCH_BYPASS_EN
    check("steady_count", dq.size(), 23);
`else
    check("steady_count", dq.size(), 22);
`endif
    for (int i = 0; i < 20; i++) check("steady_pc", (i < dq.size()) ? dq[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // Decode stalled: only the credit limit's worth of requests goes out.
    do_reset();
    repeat (20) step(1'b1, 1'b0, 1'b0, '0);
    check("stall_reqs", n_dut_fire, 4);
    check("stall_req_vld", imem_req_valid, 0);
    repeat (8) step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) check("stall_pc", (i < dq.size()) ? dq[i] : 32'hDEAD_BEEF, 32'(4 * i));
    check("resume_addr", (fq.size() > 4) ? fq[4] : 32'hDEAD_BEEF, 32'h10);

    // Randomized ready, latency and redirects.
    lat_min = 1; lat_max = 5;
    do_reset();
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), $urandom());
    check("rand_progress", (dq.size() > 50), 1);

    // Three requests in flight when the redirect lands.
    lat_min = 4; lat_max = 4;
    do_reset();
    for (int i = 0; i < 20 && memq.size() < 3; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("inflight_before_redir", memq.size(), 3);
    dq.delete();
    step(1'b1, 1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b1, 1'b0, '0);
    check("vld_after_redir", instr_valid, 0);
    repeat (15) step(1'b1, 1'b1, 1'b0, '0);
    check("redir_first_pc", (dq.size() > 0) ? dq[0] : 32'hDEAD_BEEF, 32'h100);

    // Misaligned redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (6) step(1'b1, 1'b1, 1'b0, '0);
    dq.delete();
    step(1'b1, 1'b1, 1'b1, 32'h203);
    step(1'b1, 1'b1, 1'b0, '0);
    check("redir_align_addr", imem_req_addr, 32'h200);
    repeat (10) step(1'b1, 1'b1, 1'b0, '0);
    check("redir_align_pc", (dq.size() > 0) ? dq[0] : 32'hDEAD_BEEF, 32'h200);

    // Address wrap at the top of the space.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    fq.delete();
    repeat (12) step(1'b1, 1'b1, 1'b0, '0);
    saw_wrap = 1'b0;
    for (int i = 0; i + 1 < fq.size(); i++)
      if (fq[i] == 32'hFFFF_FFFC && fq[i+1] == 32'h0) saw_wrap = 1'b1;
    check("addr_wrap", saw_wrap, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- RV32I instruction fetch stage, directly upstream of the instruction decoder.
- Generates sequential word-aligned fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Accepts in-order responses of variable latency and buffers them in a small FIFO. Presents {instr, pc} to decode with valid/ready.
- Handles redirects from branch/jump resolution by flushing buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries and maximum in-flight requests; power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  fetch address, bits [1:0] always 0.
- imem_resp_valid  input  1  response data valid; responses return in request order, 1+ cycles after acceptance, no backpressure.
- imem_resp_data  input  32  fetched instruction word.
- redirect_valid  input  1  control-flow redirect (taken branch, jal, jalr).
- redirect_pc  input  32  redirect target.
- instr_valid  output  1  FIFO head valid toward decode.
- instr  output  32  instruction word to decode.
- instr_pc  output  32  address of instr.
- instr_ready  input  1  decode consumes head.

Behaviour:
- Reset (async assert, sync deassert):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_cnt=0.
  - instr_valid=0, imem_req_valid=0, imem_req_addr=RESET_PC.
- Request issue:
  - imem_req_valid=1 iff (fifo_count + outstanding) < FIFO_DEPTH and redirect_valid=0.
  - imem_req_addr=fetch_pc.
  - On valid&&ready: fetch_pc+=4 (wraps modulo 2^32), outstanding+=1.
  - First request is presented in the first cycle after reset deassert.
- Response:
  - On imem_resp_valid: outstanding-=1.
  - If drop_cnt>0, drop the response and decrement drop_cnt.
  - Otherwise push {imem_resp_data, resp_pc} and set resp_pc+=4.
  - The credit rule guarantees the push never overflows. A response with outstanding=0 is illegal; assert in simulation.
- Output and pop:
  - instr_valid=!empty; instr and instr_pc are the FIFO head, registered from storage.
  - instr_valid&&instr_ready pops the head.
  - Push and pop may occur in the same cycle, including when the FIFO is full. Count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Base-case latency from request acceptance to instr_valid is response latency + 1 cycle.
- Redirect (priority over everything that cycle):
  - FIFO is cleared and any pop is ignored.
  - fetch_pc=resp_pc={redirect_pc[31:2],2'b00}.
  - drop_cnt = outstanding − (imem_resp_valid ? 1 : 0). A response arriving in the redirect cycle is also dropped.
  - imem_req_valid=0 in the redirect cycle. Fetch resumes the next cycle at the new pc; it need not wait for drops to drain, because responses stay ordered.
  - Back-to-back redirects: the latest wins, and drop_cnt is recomputed from the current outstanding count.
- outstanding and drop_cnt are $clog2(FIFO_DEPTH)+1 bits wide; drop_cnt ≤ outstanding always.
- Reset mid-operation clears all state immediately. Late memory responses after reset are the memory's responsibility; memory is reset together with this block.

Optional Feature:
- FETCH_BYPASS_EN:
  - Defined: when the FIFO is empty, imem_resp_valid=1 and the response is not dropped, the response drives instr/instr_pc/instr_valid combinationally in the same cycle. If instr_ready=1 it is not pushed, cutting latency to response latency + 0.
  - Not defined: all instructions pass through FIFO storage (+1 cycle).
  - Redirect still kills a bypassed response.

Decomposition:
- fetch_pkg holds:
  - RESET_PC_DEFAULT.
  - INSTR_NOP=32'h0000_0013, driven on instr when instr_valid=0.
  - fetch_entry_t struct {logic [31:0] instr; logic [31:0] pc}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty, parameterized by FIFO_DEPTH.
- PC and credit logic stays in fetch_unit.

Test Plan:
- Reset release, imem_req_ready=1, fixed 1-cycle response latency, instr_ready=1 → addrs 0x0,0x4,0x8…; instr_pc follows the same sequence with no gaps, one instr per cycle steady state.
- instr_ready=0 for 20 cycles → exactly 4 requests issued, FIFO full, imem_req_valid=0; release → 4 instrs delivered in order, fetch resumes at 0x10.
- imem_req_ready toggling 1/0 with response latency random 1–5 → delivered instr_pc strictly +4 and instr equals the memory model word at that pc.
- 3 requests outstanding, redirect_valid to 0x100 → next 3 responses dropped, next instr_pc=0x100, no stale instructions, instr_valid=0 the cycle after redirect.
- Redirect to 0x203 coincident with a response and a pop → response dropped, head discarded, next fetch addr 0x200.
- Fetch at 0xFFFF_FFFC → next addr wraps to 0x0000_0000.
